// File: rtl/accel_wb_if.sv
// Bundle of decode, accelerator, pipeline-writeback and register-file signals
// shared between the writeback scheduler and its surroundings.
interface accel_wb_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic                   dec_valid;
    logic [REG_AW-1:0]      dec_rs1;
    logic [REG_AW-1:0]      dec_rs2;
    logic [REG_AW-1:0]      dec_rd;
    logic                   dec_reg_write;
    logic                   dec_accel;
    logic                   dec_accel_sel;
    logic                   stall_out;
    logic                   fft_start;
    logic                   fft_done;
    logic [DATA_W-1:0]      fft_result;
    logic                   cry_start;
    logic                   cry_done;
    logic [DATA_W-1:0]      cry_result;
    logic                   pipe_wb_we;
    logic [REG_AW-1:0]      pipe_wb_rd;
    logic [DATA_W-1:0]      pipe_wb_data;
    logic                   rf_we;
    logic [REG_AW-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [(1<<REG_AW)-1:0] scoreboard;
    logic                   proto_err;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_reg_write, dec_accel, dec_accel_sel,
        output fft_done, fft_result, cry_done, cry_result,
        output pipe_wb_we, pipe_wb_rd, pipe_wb_data,
        input  stall_out, fft_start, cry_start, rf_we, rf_waddr, rf_wdata, scoreboard, proto_err
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_reg_write, dec_accel, dec_accel_sel,
        input  fft_done, fft_result, cry_done, cry_result,
        input  pipe_wb_we, pipe_wb_rd, pipe_wb_data,
        output stall_out, fft_start, cry_start, rf_we, rf_waddr, rf_wdata, scoreboard, proto_err
    );
endinterface

// File: rtl/accel_wb_scheduler.sv
// Issue/writeback scheduler for the FFT (engine 0) and crypto (engine 1)
// accelerators, with a per-register pending scoreboard and RF write merging.
//
// state   | meaning
// IDLE    | engine free, may accept an issue
// BUSY    | started, waiting for the done pulse
// WB_PEND | result held, waiting for a free RF write slot
module accel_wb_scheduler #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input logic       clk,
    input logic       rst,
    accel_wb_if.slave bus
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        WB_PEND = 2'd2
    } eng_state_t;

    eng_state_t        state_q [2];
    eng_state_t        state_d [2];
    logic [REG_AW-1:0] dst_q   [2];
    logic [DATA_W-1:0] hold_q  [2];
    logic [DATA_W-1:0] result  [2];
    logic [1:0]        start_q;
    logic [1:0]        done;
    logic [1:0]        done_ok;
    logic [1:0]        issue;
    logic [1:0]        grant;
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_set;
    logic [NREG-1:0]   sb_clr;
    logic              proto_q;
    logic              raw;
    logic              waw;
    logic              eng_busy;
    logic              stall;

    always_comb begin
        done      = {bus.cry_done, bus.fft_done};
        result[0] = bus.fft_result;
        result[1] = bus.cry_result;

        // Register 0 never creates a dependency.
        raw = ((bus.dec_rs1 != '0) && sb_q[bus.dec_rs1]) ||
              ((bus.dec_rs2 != '0) && sb_q[bus.dec_rs2]);
        waw = (bus.dec_reg_write || bus.dec_accel) && (bus.dec_rd != '0) && sb_q[bus.dec_rd];
        eng_busy = bus.dec_accel && (state_q[bus.dec_accel_sel] != IDLE);
        stall    = bus.dec_valid && (raw || waw || eng_busy);

        issue[0] = bus.dec_valid && bus.dec_accel && !stall && !bus.dec_accel_sel;
        issue[1] = bus.dec_valid && bus.dec_accel && !stall &&  bus.dec_accel_sel;

        grant[0] = !bus.pipe_wb_we && (state_q[0] == WB_PEND);
        grant[1] = !bus.pipe_wb_we && (state_q[1] == WB_PEND) && !grant[0];

        sb_set = '0;
        if ((issue != 2'b00) && (bus.dec_rd != '0))
            sb_set[bus.dec_rd] = 1'b1;
        sb_clr = '0;
        for (int e = 0; e < 2; e++)
            if (grant[e])
                sb_clr[dst_q[e]] = 1'b1;

        for (int e = 0; e < 2; e++) begin
            done_ok[e] = done[e] && (state_q[e] == BUSY);
            state_d[e] = state_q[e];
            case (state_q[e])
                IDLE:    if (issue[e]) state_d[e] = BUSY;
                // A zero destination has nowhere to go, so the result is dropped.
                BUSY:    if (done[e]) state_d[e] = (dst_q[e] == '0) ? IDLE : WB_PEND;
                WB_PEND: if (grant[e]) state_d[e] = IDLE;
                default: state_d[e] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                state_q[e] <= IDLE;
                dst_q[e]   <= '0;
                hold_q[e]  <= '0;
            end
            start_q <= '0;
            sb_q    <= '0;
            proto_q <= 1'b0;
        end else begin
            for (int e = 0; e < 2; e++) begin
                state_q[e] <= state_d[e];
                if (issue[e])
                    dst_q[e] <= bus.dec_rd;
                if (done_ok[e])
                    hold_q[e] <= result[e];
            end
            start_q <= issue;
            sb_q    <= (sb_q & ~sb_clr) | sb_set;
            if ((done & ~done_ok) != 2'b00)
                proto_q <= 1'b1;
        end
    end

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (bus.pipe_wb_we) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.pipe_wb_rd;
            bus.rf_wdata = bus.pipe_wb_data;
        end else if (grant[0]) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = dst_q[0];
            bus.rf_wdata = hold_q[0];
        end else if (grant[1]) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = dst_q[1];
            bus.rf_wdata = hold_q[1];
        end
    end

    assign bus.stall_out  = stall;
    assign bus.fft_start  = start_q[0];
    assign bus.cry_start  = start_q[1];
    assign bus.scoreboard = sb_q;
    assign bus.proto_err  = proto_q;
endmodule

// File: doc/accel_wb_scheduler.md
Name: accel_wb_scheduler

Overview:
- Issue and writeback scheduler between the decode stage, the FFT and crypto accelerators, and the register-file write port.
- Keeps an 8-entry scoreboard of registers awaiting an accelerator result.
- Stalls decode on RAW/WAW hazards against those registers, or when the target engine is occupied.
- Merges accelerator results onto the single RF write port; the pipeline writeback always has priority.

Parameters:
DATA_W, 16, width of register / result data
REG_AW, 3, register address width (2**REG_AW registers, r0 hardwired zero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
dec_valid  in  1  decode holds a valid instruction
dec_rs1  in  REG_AW  source register 1
dec_rs2  in  REG_AW  source register 2
dec_rd  in  REG_AW  destination register
dec_reg_write  in  1  instruction writes dec_rd
dec_accel  in  1  instruction is an accelerator op
dec_accel_sel  in  1  0 = FFT, 1 = crypto
stall_out  out  1  hold fetch/decode, inject bubble
fft_start  out  1  one-cycle start pulse to FFT
fft_done  in  1  one-cycle completion pulse from FFT
fft_result  in  DATA_W  FFT result, valid with fft_done
cry_start  out  1  one-cycle start pulse to crypto
cry_done  in  1  one-cycle completion pulse from crypto
cry_result  in  DATA_W  crypto result, valid with cry_done
pipe_wb_we  in  1  pipeline writeback valid
pipe_wb_rd  in  REG_AW  pipeline writeback register
pipe_wb_data  in  DATA_W  pipeline writeback data
rf_we  out  1  register-file write enable
rf_waddr  out  REG_AW  register-file write address
rf_wdata  out  DATA_W  register-file write data
scoreboard  out  2**REG_AW  pending-result bit per register (debug/verification)
proto_err  out  1  sticky protocol error

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst). While rst is high:
  - fft_start, cry_start, scoreboard, proto_err, and the hold registers are 0.
  - Both engines are IDLE.
  - rf_we and stall_out follow their combinational equations with empty state, i.e. rf_we = pipe_wb_we.
- Per-engine FSM: IDLE -> BUSY -> WB_PEND -> IDLE, with a destination register (dst) and a result hold register.
- Issue: fires when dec_valid & dec_accel & !stall_out for the selected engine. It causes:
  - The engine goes IDLE -> BUSY and latches dst = dec_rd.
  - The engine's start output is high for exactly the next cycle (registered).
  - scoreboard[dec_rd] sets on the same edge, unless dec_rd = 0.
- Done in BUSY:
  - Result is latched into the hold register; engine -> WB_PEND.
  - If dst = 0: engine -> IDLE directly and the result is discarded.
- Done in IDLE or WB_PEND: ignored, proto_err set (sticky until reset). Done in the same cycle as the start pulse is legal.
- stall_out is combinational and asserted when dec_valid and any of:
  - rs1 or rs2 is nonzero and its scoreboard bit is set (RAW);
  - dec_reg_write | dec_accel, dec_rd nonzero, and scoreboard[dec_rd] set (WAW);
  - dec_accel and the selected engine is not IDLE.
  - Stall is never asserted for register 0.
- RF write mux, combinational:
  - pipe_wb_we = 1: pipeline path (rf_we=1, pipeline addr/data). Pipeline always wins.
  - pipe_wb_we = 0, an engine in WB_PEND: rf_we=1, rf_waddr=dst, rf_wdata=hold. FFT has priority over crypto when both are pending.
  - The granted engine goes -> IDLE and scoreboard[dst] clears on that edge. The loser stays WB_PEND and is granted the next free cycle.
- Starvation is bounded: stalled decode injects bubbles, so pipeline writebacks drain and a free write slot occurs.
- Simultaneous events on one edge:
  - Set on issue plus clear of a different register: both take effect.
  - Set and clear of the same register cannot occur, because the WAW stall blocks the issue.
- Scoreboard bit count equals the number of engines in BUSY/WB_PEND with nonzero dst; at most 2 bits set.

Test Plan:
- Reset, no activity, pipe_wb_we=1 rd=5 data=0x1234 -> rf_we=1 addr=5 data=0x1234, stall_out=0, scoreboard=0.
- Issue FFT rd=3; next cycle decode rs1=3 -> fft_start pulses 1 cycle, scoreboard=0x08, stall_out=1. Then fft_done result=0xBEEF with pipe idle -> rf write r3=0xBEEF; scoreboard=0 and stall_out=0 the cycle after.
- FFT (rd=1) and crypto (rd=2) both done in the same cycle with pipe_wb_we=1 for 2 cycles -> no accel writes for 2 cycles, then r1 written, then r2 on the next cycle.
- Issue crypto while crypto is BUSY -> stall_out=1 and no second cry_start. Issue FFT meanwhile -> accepted.
- Issue FFT rd=0 -> scoreboard stays 0, no stall on rs=0, fft_done produces no RF write. Stray cry_done while crypto IDLE -> proto_err=1 and stays set.
- Assert rst while FFT BUSY with rd=4 -> scoreboard=0, stall released. A later fft_done is ignored and sets proto_err.
